// File: rtl/aes_word_collector.sv
// aes_word_collector: word-serial to block-parallel receiver for the AES datapath.
// It accepts 32-bit state words under a per-byte write mask and assembles four accepted words into
// a 128-bit block. The block is then offered downstream over a valid/ready handshake.
//
// Parameter:
//   MSW_FIRST    1: the first word lands in Block_out[127:96]; 0: it lands in Block_out[31:0]
// Optional feature macro:
//   AES_WORD_COLLECTOR_CLR_EN  when defined, the assembly register clears on every handoff and on
//                              Flush, so masked-off lanes read as zero.
// Ports:
//   CLOCK        rising-edge clock
//   RESET        asynchronous active-low reset
//   Word_in      incoming state word (lane 3 = [31:24])
//   Word_valid   Word_in is valid
//   Word_ready   collector accepts a word this cycle (combinational)
//   Byte_en      per-lane write enable, bit 3 = [31:24]
//   Flush        synchronous abort of the partial or held block
//   Block_out    assembled block (registered)
//   Block_valid  Block_out holds a complete block
//   Block_ready  downstream accepts the block
//   Word_count   words collected in the current block (0-3)
module aes_word_collector #(
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic [31:0]  Word_in,
  input  logic         Word_valid,
  output logic         Word_ready,
  input  logic [3:0]   Byte_en,
  input  logic         Flush,
  output logic [127:0] Block_out,
  output logic         Block_valid,
  input  logic         Block_ready,
  output logic [1:0]   Word_count
);

  typedef enum logic [0:0] {StCollect, StHold} state_e;

  state_e       state;
  state_e       state_next;
  logic [1:0]   count_next;
  logic [127:0] block_next;
  logic [1:0]   slot;
  logic         accept;
  logic         handoff;

  // State and datapath registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state      <= StCollect;
      Word_count <= 2'd0;
      Block_out  <= 128'h0;
    end else begin
      state      <= state_next;
      Word_count <= count_next;
      Block_out  <= block_next;
    end
  end

  assign accept  = Word_valid & Word_ready;
  assign handoff = Block_valid & Block_ready;

  // Next-state logic. Flush overrides any accept or handoff in the same cycle.
  always_comb begin
    state_next = state;
    count_next = Word_count;
    if (Flush) begin
      state_next = StCollect;
      count_next = 2'd0;
    end else begin
      case (state)
        StCollect: begin
          if (accept) begin
            // The count wraps 3 -> 0 as the fourth word completes the block.
            count_next = Word_count + 2'd1;
            if (Word_count == 2'd3) begin
              state_next = StHold;
            end
          end
        end
        StHold: begin
          if (handoff) begin
            state_next = StCollect;
            // A word accepted on the handoff edge is slot 0 of the next block.
            count_next = accept ? 2'd1 : 2'd0;
          end
        end
        default: state_next = StCollect;
      endcase
    end
  end

  // Slot k occupies 32-bit word index (3-k) when MSW_FIRST=1, and index k otherwise.
  // Word_count is 0 in HOLD, so an accept on the handoff edge writes slot 0.
  assign slot = MSW_FIRST ? ~Word_count : Word_count;

  always_comb begin
    block_next = Block_out;
`ifdef AES_WORD_COLLECTOR_CLR_EN
    if (Flush || handoff) begin
      block_next = 128'h0;
    end
`endif
    if (accept && !Flush) begin
      for (int b = 0; b < 4; b++) begin
        if (Byte_en[b]) begin
          block_next[{slot, 2'(b), 3'b000} +: 8] = Word_in[{2'(b), 3'b000} +: 8];
        end
      end
    end
  end

  // Outputs. Block_valid comes straight from the registered state.
  always_comb begin
    Block_valid = (state == StHold);
    Word_ready  = (state == StCollect) || Block_ready;
  end

endmodule

// File: tb/tb_aes_word_collector.sv
// Bench for aes_word_collector: two instances (MSW_FIRST=1 and 0) share one stimulus stream.
// A reference model tracks slots, count and state. Each completed block is pushed onto a
// scoreboard queue and compared while it is held.
module tb_aes_word_collector;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  word_in;
  logic         word_valid;
  logic [3:0]   byte_en;
  logic         flush;
  logic         block_ready;

  logic         ready_m, ready_l;
  logic         valid_m, valid_l;
  logic [127:0] out_m, out_l;
  logic [1:0]   cnt_m, cnt_l;

  int checks = 0;
  int errors = 0;

  // Reference model.
  logic [31:0]  m_slot [4];
  logic [1:0]   m_cnt;
  logic         m_hold;
  logic [127:0] q_m [$];
  logic [127:0] q_l [$];
  int           vcount;

  always #5 clk = ~clk;

  aes_word_collector #(.MSW_FIRST(1'b1)) dut_msw (
    .CLOCK       (clk),
    .RESET       (rst_n),
    .Word_in     (word_in),
    .Word_valid  (word_valid),
    .Word_ready  (ready_m),
    .Byte_en     (byte_en),
    .Flush       (flush),
    .Block_out   (out_m),
    .Block_valid (valid_m),
    .Block_ready (block_ready),
    .Word_count  (cnt_m)
  );

  aes_word_collector #(.MSW_FIRST(1'b0)) dut_lsw (
    .CLOCK       (clk),
    .RESET       (rst_n),
    .Word_in     (word_in),
    .Word_valid  (word_valid),
    .Word_ready  (ready_l),
    .Byte_en     (byte_en),
    .Flush       (flush),
    .Block_out   (out_l),
    .Block_valid (valid_l),
    .Block_ready (block_ready),
    .Word_count  (cnt_l)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_slot[k] = 32'h0;
    m_cnt  = 2'd0;
    m_hold = 1'b0;
    q_m.delete();
    q_l.delete();
  endtask

  task automatic model_clear();
`ifdef AES_WORD_COLLECTOR_CLR_EN
    for (int k = 0; k < 4; k++) m_slot[k] = 32'h0;
`endif
  endtask

  task automatic post_checks();
    check("valid_msw", {127'b0, valid_m}, {127'b0, m_hold});
    check("valid_lsw", {127'b0, valid_l}, {127'b0, m_hold});
    check("count_msw", {126'b0, cnt_m}, {126'b0, m_cnt});
    check("count_lsw", {126'b0, cnt_l}, {126'b0, m_cnt});
    if (m_hold && q_m.size() > 0) begin
      check("held_msw", out_m, q_m[0]);
      check("held_lsw", out_l, q_l[0]);
    end else begin
      check("part_msw", out_m, {m_slot[0], m_slot[1], m_slot[2], m_slot[3]});
      check("part_lsw", out_l, {m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
    end
    if (valid_m) vcount++;
  endtask

  // One clock cycle: drive at the falling edge, advance the model at the rising edge, sample 1 ns later.
  task automatic cyc(input logic wv, input logic [31:0] w, input logic [3:0] be,
                     input logic br, input logic fl);
    logic m_ready, acc, ho;
    logic [31:0] tmp;
    @(negedge clk);
    word_valid  = wv;
    word_in     = w;
    byte_en     = be;
    block_ready = br;
    flush       = fl;
    #1;
    m_ready = !m_hold || br;
    check("ready_msw", {127'b0, ready_m}, {127'b0, m_ready});
    check("ready_lsw", {127'b0, ready_l}, {127'b0, m_ready});
    acc = wv && m_ready;
    ho  = m_hold && br;
    @(posedge clk);
    if (fl) begin
      if (m_hold) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
      model_clear();
      m_hold = 1'b0;
      m_cnt  = 2'd0;
    end else begin
      if (ho) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
        model_clear();
        m_hold = 1'b0;
      end
      if (acc) begin
        tmp = m_slot[m_cnt];
        for (int b = 0; b < 4; b++) if (be[b]) tmp[8*b +: 8] = w[8*b +: 8];
        m_slot[m_cnt] = tmp;
        if (m_cnt == 2'd3) begin
          m_hold = 1'b1;
          m_cnt  = 2'd0;
          q_m.push_back({m_slot[0], m_slot[1], m_slot[2], m_slot[3]});
          q_l.push_back({m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
        end else begin
          m_cnt = m_cnt + 2'd1;
        end
      end
    end
    #1;
    post_checks();
  endtask

  initial begin
    logic [31:0] exp_s0;
    rst_n       = 1'b0;
    word_in     = 32'h0;
    word_valid  = 1'b0;
    byte_en     = 4'h0;
    flush       = 1'b0;
    block_ready = 1'b0;
    vcount      = 0;
    model_reset();
    #3;
    check("rst_out_msw", out_m, 128'h0);
    check("rst_out_lsw", out_l, 128'h0);
    check("rst_valid", {127'b0, valid_m}, 128'h0);
    check("rst_ready", {127'b0, ready_m}, 128'h1);
    check("rst_count", {126'b0, cnt_m}, 128'h0);
    #4 rst_n = 1'b1;

    // Block 1, back to back.
    cyc(1, 32'h00112233, 4'hF, 1, 0);
    cyc(1, 32'h44556677, 4'hF, 1, 0);
    cyc(1, 32'h8899AABB, 4'hF, 1, 0);
    cyc(1, 32'hCCDDEEFF, 4'hF, 0, 0);
    check("blk1_msw", out_m, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    check("blk1_lsw", out_l, 128'hCCDDEEFF_8899AABB_44556677_00112233);

    // Downstream stalls: no word may be consumed, block frozen.
    for (int i = 0; i < 5; i++) cyc(1, 32'h0BADF00D, 4'hF, 0, 0);

    // Handoff with a simultaneous word accept, masked to lanes 3 and 1.
    cyc(1, 32'hDEADBEEF, 4'b1010, 1, 0);
`ifdef AES_WORD_COLLECTOR_CLR_EN
    exp_s0 = 32'hDE00BE00;
`else
    exp_s0 = 32'hDE11BE33;
`endif
    check("slot0_msw", {96'b0, out_m[127:96]}, {96'b0, exp_s0});
    check("slot0_lsw", {96'b0, out_l[31:0]}, {96'b0, exp_s0});
    cyc(1, 32'h01020304, 4'b1010, 1, 0);
    cyc(1, 32'h05060708, 4'b1010, 1, 0);
    cyc(1, 32'h090A0B0C, 4'b1010, 1, 0);
    cyc(0, 32'h0, 4'h0, 1, 0);

    // Flush of a partial block drops the word presented with it.
    cyc(1, 32'hA0A1A2A3, 4'hF, 1, 0);
    cyc(1, 32'hB0B1B2B3, 4'hF, 1, 0);
    cyc(1, 32'hC0C1C2C3, 4'hF, 1, 1);
    cyc(1, 32'h10111213, 4'hF, 1, 0);
    cyc(1, 32'h20212223, 4'hF, 1, 0);
    cyc(1, 32'h30313233, 4'hF, 1, 0);
    cyc(1, 32'h40414243, 4'hF, 0, 0);
    check("clean_msw", out_m, 128'h10111213_20212223_30313233_40414243);
    // Flush in HOLD discards the held block.
    cyc(0, 32'h0, 4'h0, 0, 1);

    // Asynchronous reset while holding a block.
    for (int i = 0; i < 4; i++) cyc(1, 32'h5A5A0000 + i, 4'hF, 0, 0);
    @(negedge clk);
    word_valid = 1'b0;
    flush      = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", {127'b0, valid_m}, 128'h0);
    check("arst_out_msw", out_m, 128'h0);
    check("arst_out_lsw", out_l, 128'h0);
    check("arst_ready", {127'b0, ready_m}, 128'h1);
    check("arst_count", {126'b0, cnt_l}, 128'h0);
    #3 rst_n = 1'b1;

    // Sustained stream: 16 words, 4 blocks, no bubbles.
    vcount = 0;
    for (int i = 0; i < 16; i++) cyc(1, 32'h1000_0000 * (i + 1) + i, 4'hF, 1, 0);
    check("stream_pulses", 128'(vcount), 128'd4);
    cyc(0, 32'h0, 4'h0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
